byte_packer: RTL and testbench
==============================

# byte_packer

Packs a stream of 8-bit system-side bytes into 32-bit master-width words and delivers them over the same valid/busy handshake that the decryption top-level accepts on its input. It is the transmit-side counterpart of the decryption input path. Testbenches and the loopback path use it to feed ciphertext into the decryption datapath. An end-of-message byte forces a flush of a partially filled word. A 2-entry word FIFO decouples byte intake from downstream back-pressure.

## Interface
- MST_DWIDTH, 32, output word width; must equal 4 × SYS_DWIDTH
- SYS_DWIDTH, 8, input byte width
- EOM_BYTE, 8'hFA, end-of-message marker byte
- clk_sys  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- data_i  in  SYS_DWIDTH  input byte
- valid_i  in  1  data_i is valid this cycle
- busy  out  1  high: producer must hold its byte; the byte is not accepted
- data_o  out  MST_DWIDTH  packed word (FIFO head)
- valid_o  out  1  data_o holds a word
- busy_i  in  1  downstream back-pressure; a word transfers when valid_o && !busy_i
- msg_done  out  1  one-cycle pulse when the word containing EOM_BYTE transfers

## Operation
- Byte accept: valid_i && !busy on a rising edge.
- Lane order: the first byte of a word goes to data_o[31:24], the second to [23:16], the third to [15:8], the fourth to [7:0].
- A 2-bit lane counter (0..3) selects the lane for the next accepted byte. The accumulator register holds lanes already filled.
- Word completion: an accepted byte completes the word when lane == 3 or data_i == EOM_BYTE.
  - On completion, the word is pushed to the FIFO with unfilled lanes = 8'h00.
  - The lane counter returns to 0 and the accumulator clears.
  - The push carries a 1-bit eom tag (data_i == EOM_BYTE).
- EOM_BYTE is itself packed as a normal byte in its lane.
  - Example: EOM in lane 0 gives word {8'hFA, 24'h0}.
- FIFO: 2 entries, with count 0..2, and read/write pointers that wrap mod 2.
  - Push and pop in the same cycle are legal. The count is unchanged in that case.
  - The head drives data_o/valid_o directly from registers.
- busy = (count == 2), taken from the registered count only.
  - busy stays high in the cycle a pop occurs on a full FIFO.
  - It drops the following cycle.
- Bytes are never dropped.
  - A completing byte is accepted only when !busy, so a FIFO slot is always available for it.
  - Non-completing bytes are also blocked while busy; this keeps the rule uniform.
- msg_done pulses in the cycle after a tagged word transfers.
- Reset mid-message discards the accumulator, lane counter and FIFO contents. No partial word is emitted.

## Timing
- Reset values: data_o = 0, valid_o = 0, busy = 0, msg_done = 0, lane = 0, count = 0.
- Latency: a completing byte accepted at edge N makes valid_o = 1 with the new word after edge N, i.e. visible in cycle N+1. This assumes the FIFO was empty.
- Throughput: 1 byte/cycle sustained when busy_i is low, which gives one word every 4 cycles.
- Downstream hold: while valid_o && busy_i, data_o and valid_o are stable.
- Pop: on valid_o && !busy_i at an edge, the head advances. valid_o falls if the FIFO becomes empty.
- Empty-FIFO case: with the FIFO empty and a push in the same cycle, the pushed word appears next cycle. There is no bypass.
- valid_i while busy: no state change. The producer must hold data_i/valid_i until busy is low.
- Simultaneous push + pop at count 2 cannot occur, because busy blocks the completing byte.
- Simultaneous push + pop at count 1 leaves count = 1 and puts the new word at the head after the pop.

## Test plan
- Reset, then bytes 11,22,33,44 on consecutive cycles with busy_i = 0 → data_o = 32'h11223344 and valid_o high for exactly 1 cycle, starting the cycle after byte 44; msg_done stays 0.
- Bytes AA,BB,FA → word 32'hAABBFA00; msg_done pulses 1 cycle after the transfer; the next bytes start again at lane 0.
- busy_i held high while 12 bytes are offered → exactly 2 words queued, busy = 1 and the 9th byte held; release busy_i → words popped in order, busy falls 1 cycle after the first pop, and the 9th..12th bytes produce a third word 09..0C (byte values from 01).
- Byte FA alone in lane 0 → 32'hFA000000 with msg_done pulse; back-to-back FA,FA → two words 32'hFA000000 and two pulses.
- Assert rst after 2 bytes of a word and while 1 word is queued → valid_o = 0 and busy = 0 next cycle; new bytes 01..04 → exactly one word 32'h01020304.

Source files
------------

// File: rtl/byte_packer.sv
// byte_packer: packs SYS_DWIDTH bytes into MST_DWIDTH words, MSB lane first,
// with end-of-message flush and a 2-entry word FIFO on a valid/busy handshake.
module byte_packer #(
   parameter int                    MST_DWIDTH = 32,
   parameter int                    SYS_DWIDTH = 8,
   parameter logic [SYS_DWIDTH-1:0] EOM_BYTE   = 8'hFA
) (
   input  logic                  clk_sys,
   input  logic                  rst,
   input  logic [SYS_DWIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  busy,
   output logic [MST_DWIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  busy_i,
   output logic                  msg_done
);

   localparam int S = SYS_DWIDTH;
   localparam int M = MST_DWIDTH;

   logic [1:0]   lane_q, lane_d;
   logic [M-1:0] acc_q, acc_d;
   logic [M-1:0] word;
   logic [M-1:0] mem_q [2];
   logic         tag_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   cnt_q, cnt_d;
   logic         done_q, done_d;
   logic         accept, is_eom, push, pop;

   assign busy     = (cnt_q == 2'd2);
   assign valid_o  = (cnt_q != 2'd0);
   assign data_o   = mem_q[rd_ptr_q];
   assign msg_done = done_q;

   // Insert the incoming byte into its lane of the accumulated word
   always_comb begin
      word = acc_q;
      unique case (lane_q)
         2'd0:    word[M-1 -: S]     = data_i;
         2'd1:    word[M-1-S -: S]   = data_i;
         2'd2:    word[M-1-2*S -: S] = data_i;
         default: word[M-1-3*S -: S] = data_i;
      endcase
   end

   // Handshake decode, lane/accumulator and FIFO pointer next-state
   always_comb begin
      accept   = valid_i && !busy;
      is_eom   = (data_i == EOM_BYTE);
      push     = accept && ((lane_q == 2'd3) || is_eom);
      pop      = valid_o && !busy_i;
      lane_d   = lane_q;
      acc_d    = acc_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      done_d   = pop && tag_q[rd_ptr_q];
      if (push) begin
         lane_d   = 2'd0;
         acc_d    = '0;
         wr_ptr_d = ~wr_ptr_q;
      end else if (accept) begin
         lane_d = lane_q + 2'd1;
         acc_d  = word;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers; the FIFO slot is written on a completing byte
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         lane_q   <= 2'd0;
         acc_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
         done_q   <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         tag_q[0] <= 1'b0;
         tag_q[1] <= 1'b0;
      end else begin
         lane_q   <= lane_d;
         acc_q    <= acc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         if (push) begin
            mem_q[wr_ptr_q] <= word;
            tag_q[wr_ptr_q] <= is_eom;
         end
      end
   end

endmodule

// File: tb/tb_byte_packer.sv
// tb_byte_packer: directed and random stimulus against a queue-based
// model of byte packing, word FIFO occupancy and message-done pulses.
module tb_byte_packer;

   localparam logic [7:0] EOM = 8'hFA;

   logic        clk_sys = 1'b0;
   logic        rst     = 1'b1;
   logic [7:0]  data_i  = 8'h00;
   logic        valid_i = 1'b0;
   logic        busy;
   logic [31:0] data_o;
   logic        valid_o;
   logic        busy_i  = 1'b0;
   logic        msg_done;

   int checks   = 0;
   int failures = 0;
   int m_xfers  = 0;

   logic [31:0] mq[$];
   logic        mt[$];
   logic [7:0]  part[$];
   logic [31:0] got[$];
   logic        md_exp = 1'b0;

   byte_packer dut (
      .clk_sys  (clk_sys),
      .rst      (rst),
      .data_i   (data_i),
      .valid_i  (valid_i),
      .busy     (busy),
      .data_o   (data_o),
      .valid_o  (valid_o),
      .busy_i   (busy_i),
      .msg_done (msg_done)
   );

   always #5 clk_sys = ~clk_sys;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      valid_i = 1'b0;
      busy_i  = 1'b0;
      @(posedge clk_sys);
      #1;
      rst = 1'b0;
      mq.delete();
      mt.delete();
      part.delete();
      md_exp = 1'b0;
   endtask

   // One clock: check outputs against the model, then advance the model
   task automatic step(input logic v, input logic [7:0] d, input logic bi,
                       output logic acc);
      logic        popped;
      logic [31:0] w;
      valid_i = v;
      data_i  = d;
      busy_i  = bi;
      @(negedge clk_sys);
      chk("valid_o", 32'(valid_o), 32'(mq.size() > 0));
      chk("busy", 32'(busy), 32'(mq.size() == 2));
      chk("msg_done", 32'(msg_done), 32'(md_exp));
      if (mq.size() > 0) chk("data_o", data_o, mq[0]);
      if (valid_o && !busy_i) got.push_back(data_o);
      acc    = v && (mq.size() != 2);
      popped = (mq.size() > 0) && !bi;
      @(posedge clk_sys);
      #1;
      md_exp = 1'b0;
      if (popped) begin
         md_exp = mt[0];
         void'(mq.pop_front());
         void'(mt.pop_front());
         m_xfers++;
      end
      if (acc) begin
         part.push_back(d);
         if (part.size() == 4 || d == EOM) begin
            w = '0;
            for (int i = 0; i < part.size(); i++) w[31-8*i -: 8] = part[i];
            mq.push_back(w);
            mt.push_back(d == EOM);
            part.delete();
         end
      end
   endtask

   task automatic send(input logic [7:0] d, input logic bi);
      logic a;
      int   n;
      n = 0;
      a = 1'b0;
      while (!a && n < 40) begin
         step(1'b1, d, bi, a);
         n++;
      end
      chk("accept", 32'(a), 32'd1);
   endtask

   task automatic idle(input int n, input logic bi);
      logic a;
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, bi, a);
   endtask

   initial begin
      int          g;
      logic        a;
      logic        v;
      logic        bi;
      logic        pend;
      logic [7:0]  d;

      do_reset();
      chk("rst_data_o", data_o, 32'h0);
      chk("rst_valid_o", 32'(valid_o), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_msg_done", 32'(msg_done), 32'd0);

      g = got.size();
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      idle(2, 1'b0);
      chk("w4_count", 32'(got.size()), 32'(g + 1));
      chk("w4_data", got[g], 32'h11223344);

      g = got.size();
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      send(EOM, 1'b0);
      idle(3, 1'b0);
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      send(8'h77, 1'b0);
      send(8'h88, 1'b0);
      idle(2, 1'b0);
      chk("eom_count", 32'(got.size()), 32'(g + 2));
      chk("eom_data", got[g], 32'hAABBFA00);
      chk("after_eom", got[g+1], 32'h55667788);

      g = got.size();
      for (int b = 1; b <= 8; b++) send(8'(b), 1'b1);
      step(1'b1, 8'h09, 1'b1, a);
      step(1'b1, 8'h09, 1'b1, a);
      chk("full_busy", 32'(busy), 32'd1);
      chk("full_valid", 32'(valid_o), 32'd1);
      for (int b = 9; b <= 12; b++) send(8'(b), 1'b0);
      idle(3, 1'b0);
      chk("bp_count", 32'(got.size()), 32'(g + 3));
      chk("bp_w0", got[g], 32'h01020304);
      chk("bp_w1", got[g+1], 32'h05060708);
      chk("bp_w2", got[g+2], 32'h090A0B0C);

      g = got.size();
      send(EOM, 1'b0);
      idle(2, 1'b0);
      send(EOM, 1'b0);
      send(EOM, 1'b0);
      idle(3, 1'b0);
      chk("fa_count", 32'(got.size()), 32'(g + 3));
      chk("fa_w0", got[g], 32'hFA000000);
      chk("fa_w1", got[g+1], 32'hFA000000);
      chk("fa_w2", got[g+2], 32'hFA000000);

      for (int b = 8'h21; b <= 8'h26; b++) send(8'(b), 1'b1);
      do_reset();
      chk("mid_rst_valid", 32'(valid_o), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      g = got.size();
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      idle(3, 1'b0);
      chk("rst_count", 32'(got.size()), 32'(g + 1));
      chk("rst_word", got[g], 32'h01020304);

      pend = 1'b0;
      v    = 1'b0;
      d    = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (!pend) begin
            v = ($urandom % 4) != 0;
            d = (($urandom % 6) == 0) ? EOM : 8'($urandom);
         end
         bi = ($urandom % 3) == 0;
         step(v, d, bi, a);
         pend = v && !a;
      end
      idle(6, 1'b0);
      chk("drain_valid", 32'(valid_o), 32'd0);
      chk("xfer_total", 32'(got.size()), 32'(m_xfers));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
